// File: rtl/bconv_pkg.sv
// -----------------------------------------------------------------------------
// bconv_pkg
// Shared definitions for the binary-conv ternary quantiser:
//   - ternary activation codes (bit0 = nonzero, bit1 = sign)
//   - threshold pair layout {thr_hi, thr_lo} as stored in the table
//   - index width helper for channel / pixel counters
// -----------------------------------------------------------------------------
package bconv_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    // Threshold width the pair struct is laid out for (default build).
    localparam int PKG_THR_W = 27;

    typedef struct packed {
        logic signed [PKG_THR_W-1:0] thr_hi;
        logic signed [PKG_THR_W-1:0] thr_lo;
    } thr_pair_t;

    // Address width for a table/counter of n entries; never narrower than 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bconv_thr_ram.sv
// -----------------------------------------------------------------------------
// bconv_thr_ram
// Simple dual-port RAM, one write port and one read port with a single
// registered read stage (maps onto block RAM). Contents are not reset.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, data appears on rdata_o one clock later
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module bconv_thr_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 54,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bconv_ternary_quant.sv
// -----------------------------------------------------------------------------
// bconv_ternary_quant
// Converts the signed per-pixel conv result stream into 2-bit ternary codes
// using a per-channel {thr_hi, thr_lo} table loaded serially once per frame.
// Data and framing are delayed by exactly two clocks.
//
// Framing: i_valid qualifies i_tdata for exactly one cycle; there is no
// backpressure, so a beat is accepted every cycle i_valid is high. o_valid
// qualifies o_tdata the same way, and o_tdata is 00 whenever o_valid is low.
//
// Ports:
//   i_sclk, i_rst_n          clock, async active-low reset
//   i_vsync                  frame sync: clears pointers, flags, error, pipe valid
//   i_hsync                  start of row sweep (arms channel rewind)
//   i_reuse                  start of one channel segment
//   i_valid, i_tdata         input beat (signed WIDTH_O)
//   i_thr_vld, i_thr_data    threshold write strobe / {thr_hi, thr_lo}
//   o_thr_ready              all CHANNEL entries loaded this frame
//   o_vsync/hsync/reuse/valid  inputs delayed by 2
//   o_tdata                  ternary code
//   o_err                    sticky framing/load error
// -----------------------------------------------------------------------------
module bconv_ternary_quant
    import bconv_pkg::*;
#(
    parameter int WIDTH_O = 27,
    parameter int THR_W   = 27,
    parameter int CHANNEL = 256,
    parameter int SIZE    = 56,
    parameter int WIDTH_D = 2
) (
    input  logic                      i_sclk,
    input  logic                      i_rst_n,
    input  logic                      i_vsync,
    input  logic                      i_hsync,
    input  logic                      i_reuse,
    input  logic                      i_valid,
    input  logic signed [WIDTH_O-1:0] i_tdata,
    input  logic                      i_thr_vld,
    input  logic [2*THR_W-1:0]        i_thr_data,
    output logic                      o_thr_ready,
    output logic                      o_vsync,
    output logic                      o_hsync,
    output logic                      o_reuse,
    output logic                      o_valid,
    output logic [WIDTH_D-1:0]        o_tdata,
    output logic                      o_err
);

    localparam int IDX_W = idx_width(CHANNEL);
    localparam int PIX_W = idx_width(SIZE + 1);
    localparam int CMP_W = (WIDTH_O > THR_W) ? WIDTH_O : THR_W;
    localparam int TBL_W = 2 * THR_W;
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(CHANNEL - 1);
    localparam logic [PIX_W-1:0] FULL_PIX = PIX_W'(SIZE);

    // Control state
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             thr_ready_q, thr_ready_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic             armed_q, armed_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             err_q, err_d;

    // Stage 1
    logic                      s1_valid_q, s1_vsync_q, s1_hsync_q, s1_reuse_q, s1_rdy_q;
    logic signed [WIDTH_O-1:0] s1_data_q;

    // Stage 2 (outputs)
    logic       vsync_q, hsync_q, reuse_q, valid_q;
    logic [1:0] tdata_q;

    logic             tbl_we;
    logic [TBL_W-1:0] tbl_rdata;
    logic             pix_ovf;
    logic [1:0]       code_d;
    logic signed [CMP_W-1:0] x_ext, hi_ext, lo_ext;

    // Writes after the table is full are dropped (and flagged below).
    assign tbl_we = i_thr_vld && !thr_ready_q && !i_vsync;

    // Read address is the next-state channel index so a beat arriving with
    // i_reuse already sees its new channel's thresholds.
    bconv_thr_ram #(
        .DEPTH  (CHANNEL),
        .DATA_W (TBL_W),
        .ADDR_W (IDX_W)
    ) u_thr_ram (
        .clk_i   (i_sclk),
        .we_i    (tbl_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_thr_data),
        .raddr_i (ch_idx_d),
        .rdata_o (tbl_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        thr_ready_d = thr_ready_q;
        if (i_vsync) begin
            wr_ptr_d    = '0;
            thr_ready_d = 1'b0;
        end else if (tbl_we) begin
            if (wr_ptr_q == LAST_CH) begin
                wr_ptr_d    = '0;
                thr_ready_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
        end
    end

    // Channel walk: the first reuse after hsync/vsync rewinds to channel 0,
    // every later reuse steps to the next channel.
    always_comb begin
        ch_idx_d = ch_idx_q;
        armed_d  = armed_q;
        if (i_vsync) begin
            ch_idx_d = '0;
            armed_d  = 1'b1;
        end else if (i_reuse) begin
            if (armed_q || i_hsync) begin
                ch_idx_d = '0;
                armed_d  = 1'b0;
            end else begin
                ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + IDX_W'(1);
            end
        end else if (i_hsync) begin
            armed_d = 1'b1;
        end
    end

    // Segment pixel count saturates at SIZE; a beat beyond that is an error.
    assign pix_ovf = i_valid && !i_reuse && !i_vsync && (pix_cnt_q == FULL_PIX);

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (i_vsync) begin
            pix_cnt_d = '0;
        end else if (i_reuse) begin
            pix_cnt_d = i_valid ? PIX_W'(1) : '0;
        end else if (i_valid && (pix_cnt_q != FULL_PIX)) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
    end

    // Signed compare at the wider of the data and threshold widths.
    always_comb begin
        x_ext  = CMP_W'(s1_data_q);
        hi_ext = CMP_W'($signed(tbl_rdata[TBL_W-1:THR_W]));
        lo_ext = CMP_W'($signed(tbl_rdata[THR_W-1:0]));
        code_d = TERN_ZERO;
        if (s1_valid_q && s1_rdy_q) begin
            if (x_ext >= hi_ext) begin
                code_d = TERN_POS;
            end else if (x_ext <= lo_ext) begin
                code_d = TERN_NEG;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (i_vsync) begin
            err_d = 1'b0;
        end else if ((i_thr_vld && thr_ready_q) || pix_ovf || (s1_valid_q && !s1_rdy_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            thr_ready_q <= 1'b0;
            ch_idx_q    <= '0;
            armed_q     <= 1'b1;
            pix_cnt_q   <= '0;
            err_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_hsync_q  <= 1'b0;
            s1_reuse_q  <= 1'b0;
            s1_rdy_q    <= 1'b0;
            s1_data_q   <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            reuse_q     <= 1'b0;
            valid_q     <= 1'b0;
            tdata_q     <= TERN_ZERO;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            thr_ready_q <= thr_ready_d;
            ch_idx_q    <= ch_idx_d;
            armed_q     <= armed_d;
            pix_cnt_q   <= pix_cnt_d;
            err_q       <= err_d;
            // A vsync drops the beat entering and the beat already in stage 1;
            // the sync bits themselves keep propagating.
            s1_valid_q  <= i_valid && !i_vsync;
            s1_vsync_q  <= i_vsync;
            s1_hsync_q  <= i_hsync;
            s1_reuse_q  <= i_reuse;
            s1_rdy_q    <= thr_ready_q;
            s1_data_q   <= i_tdata;
            vsync_q     <= s1_vsync_q;
            hsync_q     <= s1_hsync_q;
            reuse_q     <= s1_reuse_q;
            valid_q     <= s1_valid_q && !i_vsync;
            tdata_q     <= i_vsync ? TERN_ZERO : code_d;
        end
    end

    assign o_thr_ready = thr_ready_q;
    assign o_vsync     = vsync_q;
    assign o_hsync     = hsync_q;
    assign o_reuse     = reuse_q;
    assign o_valid     = valid_q;
    assign o_tdata     = tdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_bconv_ternary_quant.sv
module tb_bconv_ternary_quant;
    import bconv_pkg::*;

    localparam int WO = 27;
    localparam int TW = 27;
    localparam int CH = 256;
    localparam int SZ = 56;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            i_vsync = 1'b0, i_hsync = 1'b0, i_reuse = 1'b0, i_valid = 1'b0;
    logic [WO-1:0]   i_tdata = '0;
    logic            i_thr_vld = 1'b0;
    logic [2*TW-1:0] i_thr_data = '0;
    logic            o_thr_ready, o_vsync, o_hsync, o_reuse, o_valid, o_err;
    logic [1:0]      o_tdata;

    bconv_ternary_quant #(
        .WIDTH_O (WO), .THR_W (TW), .CHANNEL (CH), .SIZE (SZ), .WIDTH_D (2)
    ) dut (
        .i_sclk      (clk),
        .i_rst_n     (rst_n),
        .i_vsync     (i_vsync),
        .i_hsync     (i_hsync),
        .i_reuse     (i_reuse),
        .i_valid     (i_valid),
        .i_tdata     (i_tdata),
        .i_thr_vld   (i_thr_vld),
        .i_thr_data  (i_thr_data),
        .o_thr_ready (o_thr_ready),
        .o_vsync     (o_vsync),
        .o_hsync     (o_hsync),
        .o_reuse     (o_reuse),
        .o_valid     (o_valid),
        .o_tdata     (o_tdata),
        .o_err       (o_err)
    );

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [1:0]  exp_q[$];
    int unsigned due_q[$];
    logic [1:0]  mon_code;
    int unsigned mon_due;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every output beat is matched in order against the expected queue,
    // including its arrival cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_valid, 1'b0);
                end else begin
                    mon_code = exp_q.pop_front();
                    mon_due  = due_q.pop_front();
                    check("tdata", o_tdata, mon_code);
                    check("latency", cyc, mon_due);
                end
            end else begin
                check("idle_code_zero", o_tdata, TERN_ZERO);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic hs, input logic ru);
        i_hsync = hs;
        i_reuse = ru;
        step(1);
        i_hsync = 1'b0;
        i_reuse = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_vsync = 1'b1;
        step(1);
        i_vsync = 1'b0;
    endtask

    task automatic beat(input int x, input logic [1:0] code, input logic hs, input logic ru);
        i_valid = 1'b1;
        i_tdata = WO'(x);
        i_hsync = hs;
        i_reuse = ru;
        exp_q.push_back(code);
        due_q.push_back(cyc + 2);
        step(1);
        i_valid = 1'b0;
        i_tdata = '0;
        i_hsync = 1'b0;
        i_reuse = 1'b0;
    endtask

    task automatic load_table(input int hi, input int lo, input int sp_ch, input int sp_hi, input int sp_lo);
        thr_pair_t p;
        for (int c = 0; c < CH; c++) begin
            if (c == CH - 1) check("thr_ready_before_last", o_thr_ready, 1'b0);
            p.thr_hi   = TW'((c == sp_ch) ? sp_hi : hi);
            p.thr_lo   = TW'((c == sp_ch) ? sp_lo : lo);
            i_thr_vld  = 1'b1;
            i_thr_data = p;
            step(1);
        end
        i_thr_vld  = 1'b0;
        i_thr_data = '0;
        check("thr_ready_after_load", o_thr_ready, 1'b1);
    endtask

    // hi = 100 / lo = -100 sequence, with hsync/reuse alignment checks.
    task automatic run_basic();
        pulse(1'b1, 1'b0);
        beat(150, TERN_POS, 1'b0, 1'b1);
        check("hsync_at_plus2", o_hsync, 1'b1);
        beat(100, TERN_POS, 1'b0, 1'b0);
        check("reuse_at_plus2", o_reuse, 1'b1);
        check("hsync_one_cycle", o_hsync, 1'b0);
        beat(99,   TERN_ZERO, 1'b0, 1'b0);
        beat(0,    TERN_ZERO, 1'b0, 1'b0);
        beat(-100, TERN_NEG,  1'b0, 1'b0);
        beat(-101, TERN_NEG,  1'b0, 1'b0);
        step(3);
        check("basic_no_err", o_err, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        thr_pair_t p;

        step(2);
        check("rst_valid", o_valid, 1'b0);
        check("rst_tdata", o_tdata, TERN_ZERO);
        check("rst_ready", o_thr_ready, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_syncs", {o_vsync, o_hsync, o_reuse}, 3'b000);
        rst_n = 1'b1;
        step(1);

        // Basic threshold sweep
        load_table(100, -100, -1, 0, 0);
        run_basic();

        // Channel walk: only channel 5 has tight thresholds
        vsync_pulse();
        load_table(1000, -1000, 5, 10, -10);
        pulse(1'b1, 1'b0);
        for (int s = 0; s < 6; s++) begin
            beat(20,  (s == 5) ? TERN_POS : TERN_ZERO, 1'b0, 1'b1);
            beat(-20, (s == 5) ? TERN_NEG : TERN_ZERO, 1'b0, 1'b0);
        end
        step(3);

        // Wrap: 257th reuse lands on channel 0, 262nd on channel 5
        pulse(1'b1, 1'b0);
        for (int r = 1; r <= 262; r++) begin
            if (r == 6 || r == 262) beat(20, TERN_POS, 1'b0, 1'b1);
            else if (r == 256 || r == 257) beat(20, TERN_ZERO, 1'b0, 1'b1);
            else pulse(1'b0, 1'b1);
        end
        // hsync + reuse together rewinds to channel 0; four more steps reach 5
        beat(20, TERN_ZERO, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++) pulse(1'b0, 1'b1);
        beat(20, TERN_POS, 1'b0, 1'b1);
        step(3);
        check("walk_no_err", o_err, 1'b0);

        // Error: valid with the table not loaded this frame
        vsync_pulse();
        check("vsync_clears_ready", o_thr_ready, 1'b0);
        beat(5000, TERN_ZERO, 1'b0, 1'b1);
        step(3);
        check("err_unloaded", o_err, 1'b1);
        vsync_pulse();
        check("err_clr_unloaded", o_err, 1'b0);

        // Error: 57 beats in one segment; the extra beat is still processed
        load_table(100, -100, -1, 0, 0);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < SZ; i++) beat(0, TERN_ZERO, 1'b0, (i == 0));
        step(3);
        check("err_full_segment_ok", o_err, 1'b0);
        beat(150, TERN_POS, 1'b0, 1'b0);
        step(3);
        check("err_overflow", o_err, 1'b1);
        vsync_pulse();
        check("err_clr_overflow", o_err, 1'b0);

        // Error: 257th threshold strobe is ignored
        load_table(100, -100, -1, 0, 0);
        check("err_after_load", o_err, 1'b0);
        p.thr_hi   = TW'(5);
        p.thr_lo   = TW'(-5);
        i_thr_vld  = 1'b1;
        i_thr_data = p;
        step(1);
        i_thr_vld  = 1'b0;
        check("err_extra_strobe", o_err, 1'b1);
        check("ready_after_extra", o_thr_ready, 1'b1);
        pulse(1'b1, 1'b0);
        beat(50, TERN_ZERO, 1'b0, 1'b1);   // ch0 must still hold hi = 100
        step(3);
        vsync_pulse();
        check("err_clr_strobe", o_err, 1'b0);
        check("ready_clr_strobe", o_thr_ready, 1'b0);

        // Mid-stream vsync with two beats in flight
        load_table(100, -100, -1, 0, 0);
        pulse(1'b1, 1'b0);
        i_valid = 1'b1; i_tdata = WO'(150); i_reuse = 1'b1;
        step(1);
        i_tdata = WO'(-150); i_reuse = 1'b0; i_vsync = 1'b1;
        step(1);
        i_valid = 1'b0; i_tdata = '0; i_vsync = 1'b0;
        check("vs_drop_first", o_valid, 1'b0);
        check("vs_not_yet", o_vsync, 1'b0);
        step(1);
        check("vs_drop_second", o_valid, 1'b0);
        check("vs_at_plus2", o_vsync, 1'b1);
        check("vs_ready_clr", o_thr_ready, 1'b0);
        step(2);

        // Async reset between edges with a beat on the output
        load_table(100, -100, -1, 0, 0);
        i_thr_vld = 1'b1;
        step(1);
        i_thr_vld = 1'b0;
        check("pre_reset_err", o_err, 1'b1);
        pulse(1'b1, 1'b0);
        beat(150, TERN_POS, 1'b0, 1'b1);
        beat(-150, TERN_NEG, 1'b0, 1'b0);
        check("pre_reset_valid", o_valid, 1'b1);
        #2;
        exp_q.delete();
        due_q.delete();
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", o_valid, 1'b0);
        check("async_tdata", o_tdata, TERN_ZERO);
        check("async_err", o_err, 1'b0);
        check("async_ready", o_thr_ready, 1'b0);
        check("async_syncs", {o_vsync, o_hsync, o_reuse}, 3'b000);
        step(2);
        rst_n = 1'b1;
        step(1);

        load_table(100, -100, -1, 0, 0);
        run_basic();

        step(4);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
